// File: rtl/mmss_timer_counter.sv
// ---------------------------------------------------------------------------
// mmss_timer_counter
//
// BCD minutes:seconds counter for the stopwatch display path. It counts up
// as a stopwatch or down as a countdown timer. A built-in prescaler makes the
// one-second tick from clk. Each digit can be written directly, and written
// values are clamped to the legal range.
//
// Parameters
//   TICK_DIV  clk cycles per count step (>= 1; 1 = step every enabled cycle)
//   MAX_MIN   highest minute value (1..99)
//   WRAP      up-count at MAX_MIN:59: 1 = wrap to 00:00, 0 = saturate + done
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset (overrides every other input)
//   run        1 = prescaler advances and the count steps; 0 = everything held
//   mode_down  0 = count up, 1 = count down
//   adj_we     single-cycle digit write strobe
//   adj_sel    digit select: 0 min_t, 1 min_o, 2 sec_t, 3 sec_o
//   adj_val    BCD value to write (clamped)
//   min_t/min_o/sec_t/sec_o  registered digit outputs
//   step       1-cycle pulse in the cycle updated digits first appear
//   wrapped    1-cycle pulse alongside step when the up-count wraps to 00:00
//   done       sticky: countdown reached 00:00, or the up-count saturated
// ---------------------------------------------------------------------------
module mmss_timer_counter #(
  parameter int TICK_DIV = 100000000,
  parameter int MAX_MIN  = 99,
  parameter bit WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_down,
  input  logic       adj_we,
  input  logic [1:0] adj_sel,
  input  logic [3:0] adj_val,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       step,
  output logic       wrapped,
  output logic       done
);

  // Prescaler width. Keep at least one bit so that TICK_DIV = 1 still elaborates.
  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

  // The minute limit split into BCD digits. Minute comparisons are done digit by digit.
  localparam logic [3:0]      MAX_T    = 4'(MAX_MIN / 10);
  localparam logic [3:0]      MAX_O    = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {
    SEL_MIN_T = 2'd0,
    SEL_MIN_O = 2'd1,
    SEL_SEC_T = 2'd2,
    SEL_SEC_O = 2'd3
  } digit_sel_e;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } mmss_t;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  mmss_t         cur;
  mmss_t         nxt;
  logic          step_d;
  logic          wrapped_d;
  logic          done_d;
  logic          mode_q;
  logic          tick;
  logic          done_eff;
  logic          at_top;
  logic          at_zero;
  logic          at_one;

  assign cur = '{mt: min_t, mo: min_o, st: sec_t, so: sec_o};

  // The tick is only real when the prescaler actually advances in this cycle.
  assign tick     = run && !adj_we && (pre_q == PRE_LAST);

  // A change of direction releases a sticky done. It is seen as a mismatch against
  // last cycle's mode. Because it is folded in here, a tick in the same cycle
  // already steps in the new direction.
  assign done_eff = done && (mode_down == mode_q);

  assign at_top   = (cur.mt == MAX_T) && (cur.mo == MAX_O) &&
                    (cur.st == 4'd5)  && (cur.so == 4'd9);
  assign at_zero  = (cur == '0);
  assign at_one   = (cur.mt == 4'd0) && (cur.mo == 4'd0) &&
                    (cur.st == 4'd0) && (cur.so == 4'd1);

  // NOTE: every signal this block drives gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pre_d     = pre_q;
    nxt       = cur;
    step_d    = 1'b0;
    wrapped_d = 1'b0;
    done_d    = done_eff;

    if (adj_we) begin
      // A write wins over a coincident tick. The partial second is discarded.
      pre_d  = '0;
      done_d = 1'b0;
      unique case (digit_sel_e'(adj_sel))
        SEL_MIN_T: nxt.mt = (adj_val > MAX_T) ? MAX_T : adj_val;
        SEL_MIN_O: nxt.mo = (adj_val > 4'd9)  ? 4'd9  : adj_val;
        SEL_SEC_T: nxt.st = (adj_val > 4'd5)  ? 4'd5  : adj_val;
        SEL_SEC_O: nxt.so = (adj_val > 4'd9)  ? 4'd9  : adj_val;
        default:   nxt    = cur;
      endcase
      // After the write, the tens digit is always <= MAX_T. So the only way the
      // minutes can exceed the limit is through the ones digit when tens == MAX_T.
      if ((nxt.mt > MAX_T) || ((nxt.mt == MAX_T) && (nxt.mo > MAX_O))) begin
        nxt.mo = MAX_O;
      end
    end else if (run) begin
      pre_d = tick ? '0 : pre_q + PW'(1);

      if (tick && !done_eff) begin
        if (!mode_down) begin
          // Up-count
          if (at_top) begin
            if (WRAP) begin
              nxt       = '0;
              step_d    = 1'b1;
              wrapped_d = 1'b1;
            end else begin
              // Saturate: hold the digits and report done. No step is generated.
              done_d = 1'b1;
            end
          end else begin
            step_d = 1'b1;
            if (cur.so != 4'd9) begin
              nxt.so = cur.so + 4'd1;
            end else begin
              nxt.so = 4'd0;
              if (cur.st != 4'd5) begin
                nxt.st = cur.st + 4'd1;
              end else begin
                nxt.st = 4'd0;
                if (cur.mo != 4'd9) begin
                  nxt.mo = cur.mo + 4'd1;
                end else begin
                  nxt.mo = 4'd0;
                  nxt.mt = cur.mt + 4'd1;
                end
              end
            end
          end
        end else begin
          // Down-count
          if (at_zero) begin
            // Already at zero (e.g. after an adjust). Flag done and leave the digits as they are.
            done_d = 1'b1;
          end else begin
            step_d = 1'b1;
            done_d = at_one;
            if (cur.so != 4'd0) begin
              nxt.so = cur.so - 4'd1;
            end else begin
              nxt.so = 4'd9;
              if (cur.st != 4'd0) begin
                nxt.st = cur.st - 4'd1;
              end else begin
                nxt.st = 4'd5;
                if (cur.mo != 4'd0) begin
                  nxt.mo = cur.mo - 4'd1;
                end else begin
                  nxt.mo = 4'd9;
                  nxt.mt = cur.mt - 4'd1;
                end
              end
            end
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only. Then every flop
  // samples the values from before the edge, whatever the order of evaluation.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      min_t   <= 4'd0;
      min_o   <= 4'd0;
      sec_t   <= 4'd0;
      sec_o   <= 4'd0;
      step    <= 1'b0;
      wrapped <= 1'b0;
      done    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      min_t   <= nxt.mt;
      min_o   <= nxt.mo;
      sec_t   <= nxt.st;
      sec_o   <= nxt.so;
      step    <= step_d;
      wrapped <= wrapped_d;
      done    <= done_d;
    end
  end

  // NOTE: the mode history deliberately has no reset. It follows mode_down even
  // while rst is asserted. So the first cycle after reset never sees a false
  // mode change.
  always_ff @(posedge clk) begin
    mode_q <= mode_down;
  end

endmodule

// File: tb/tb_mmss_timer_counter.sv
// ---------------------------------------------------------------------------
// Testbench for mmss_timer_counter.
//
// Three instances share one set of inputs:
//   u0: TICK_DIV=4, MAX_MIN=2,  WRAP=1
//   u1: TICK_DIV=4, MAX_MIN=2,  WRAP=0
//   u2: TICK_DIV=3, MAX_MIN=45, WRAP=1
// The reference model keeps time as plain integers (minutes, seconds, total
// seconds) and applies the counting, clamping and done rules arithmetically.
// ---------------------------------------------------------------------------
module tb_mmss_timer_counter;

  logic       clk;
  logic       rst;
  logic       run;
  logic       mode_down;
  logic       adj_we;
  logic [1:0] adj_sel;
  logic [3:0] adj_val;

  logic [3:0] mt [3];
  logic [3:0] mo [3];
  logic [3:0] st [3];
  logic [3:0] so [3];
  logic       stp [3];
  logic       wrp [3];
  logic       dn [3];

  int td  [3] = '{4, 4, 3};
  int mx  [3] = '{2, 2, 45};
  int wr  [3] = '{1, 0, 1};

  // Reference model state
  int mins    [3];
  int secs    [3];
  int presc   [3];
  bit e_done  [3];
  bit e_step  [3];
  bit e_wrap  [3];
  bit m_modeq [3];

  int n_assert = 0;
  int n_fail   = 0;
  int cycle_no = 0;
  int pulses;

  mmss_timer_counter #(.TICK_DIV(4), .MAX_MIN(2), .WRAP(1'b1)) u0 (
    .clk(clk), .rst(rst), .run(run), .mode_down(mode_down), .adj_we(adj_we),
    .adj_sel(adj_sel), .adj_val(adj_val), .min_t(mt[0]), .min_o(mo[0]),
    .sec_t(st[0]), .sec_o(so[0]), .step(stp[0]), .wrapped(wrp[0]), .done(dn[0]));

  mmss_timer_counter #(.TICK_DIV(4), .MAX_MIN(2), .WRAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .run(run), .mode_down(mode_down), .adj_we(adj_we),
    .adj_sel(adj_sel), .adj_val(adj_val), .min_t(mt[1]), .min_o(mo[1]),
    .sec_t(st[1]), .sec_o(so[1]), .step(stp[1]), .wrapped(wrp[1]), .done(dn[1]));

  mmss_timer_counter #(.TICK_DIV(3), .MAX_MIN(45), .WRAP(1'b1)) u2 (
    .clk(clk), .rst(rst), .run(run), .mode_down(mode_down), .adj_we(adj_we),
    .adj_sel(adj_sel), .adj_val(adj_val), .min_t(mt[2]), .min_o(mo[2]),
    .sec_t(st[2]), .sec_o(so[2]), .step(stp[2]), .wrapped(wrp[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cycle_no, obs, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Advances the model by one clock edge, using the inputs as they are now.
  task automatic model_update();
    bit d;
    bit tk;
    int tot;
    int v;
    for (int i = 0; i < 3; i++) begin
      e_step[i] = 1'b0;
      e_wrap[i] = 1'b0;
      if (rst) begin
        mins[i]   = 0;
        secs[i]   = 0;
        presc[i]  = 0;
        e_done[i] = 1'b0;
      end else begin
        d = e_done[i] && (mode_down == m_modeq[i]);
        if (adj_we) begin
          presc[i] = 0;
          d        = 1'b0;
          v        = int'(adj_val);
          case (adj_sel)
            2'd0: mins[i] = min_i(v, mx[i] / 10) * 10 + mins[i] % 10;
            2'd1: mins[i] = (mins[i] / 10) * 10 + min_i(v, 9);
            2'd2: secs[i] = min_i(v, 5) * 10 + secs[i] % 10;
            default: secs[i] = (secs[i] / 10) * 10 + min_i(v, 9);
          endcase
          if (mins[i] > mx[i]) mins[i] = (mins[i] / 10) * 10 + mx[i] % 10;
        end else if (run) begin
          tk       = (presc[i] == td[i] - 1);
          presc[i] = tk ? 0 : presc[i] + 1;
          if (tk && !d) begin
            tot = mins[i] * 60 + secs[i];
            if (!mode_down) begin
              if (tot == mx[i] * 60 + 59) begin
                if (wr[i] != 0) begin
                  tot       = 0;
                  e_step[i] = 1'b1;
                  e_wrap[i] = 1'b1;
                end else begin
                  d = 1'b1;
                end
              end else begin
                tot++;
                e_step[i] = 1'b1;
              end
            end else begin
              if (tot == 0) begin
                d = 1'b1;
              end else begin
                tot--;
                e_step[i] = 1'b1;
                if (tot == 0) d = 1'b1;
              end
            end
            mins[i] = tot / 60;
            secs[i] = tot % 60;
          end
        end
        e_done[i] = d;
      end
      m_modeq[i] = mode_down;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.min_t", i),   32'(mt[i]),  32'(mins[i] / 10));
      check($sformatf("u%0d.min_o", i),   32'(mo[i]),  32'(mins[i] % 10));
      check($sformatf("u%0d.sec_t", i),   32'(st[i]),  32'(secs[i] / 10));
      check($sformatf("u%0d.sec_o", i),   32'(so[i]),  32'(secs[i] % 10));
      check($sformatf("u%0d.step", i),    32'(stp[i]), 32'(e_step[i]));
      check($sformatf("u%0d.wrapped", i), 32'(wrp[i]), 32'(e_wrap[i]));
      check($sformatf("u%0d.done", i),    32'(dn[i]),  32'(e_done[i]));
    end
  endtask

  // One clock: step the model, let the edge happen, then sample 1 time unit later.
  task automatic cyc();
    model_update();
    @(posedge clk);
    #1;
    cycle_no++;
    check_all();
  endtask

  task automatic adj(input logic [1:0] sel, input logic [3:0] val);
    adj_we  = 1'b1;
    adj_sel = sel;
    adj_val = val;
    cyc();
    adj_we  = 1'b0;
  endtask

  task automatic check_mmss(input int i, input string tag, input int m, input int s);
    check({tag, ".min_t"}, 32'(mt[i]), 32'(m / 10));
    check({tag, ".min_o"}, 32'(mo[i]), 32'(m % 10));
    check({tag, ".sec_t"}, 32'(st[i]), 32'(s / 10));
    check({tag, ".sec_o"}, 32'(so[i]), 32'(s % 10));
  endtask

  initial begin
    rst       = 1'b1;
    run       = 1'b0;
    mode_down = 1'b0;
    adj_we    = 1'b0;
    adj_sel   = 2'd0;
    adj_val   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      mins[i] = 0; secs[i] = 0; presc[i] = 0;
      e_done[i] = 0; e_step[i] = 0; e_wrap[i] = 0; m_modeq[i] = 0;
    end
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    check_mmss(0, "reset", 0, 0);
    check("reset.step", 32'(stp[0]), 32'd0);
    check("reset.done", 32'(dn[0]), 32'd0);

    // 1: up-count from 00:00 for 40 cycles at TICK_DIV=4
    run    = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (stp[0]) pulses++;
    end
    check("t1.pulses", 32'(pulses), 32'd10);
    check_mmss(0, "t1", 0, 10);
    check_mmss(2, "t1.u2", 0, 13);

    // 2: adjust to 02:59, then one tick. WRAP=1 wraps; WRAP=0 saturates.
    run = 1'b0;
    adj(2'd0, 4'd0);
    adj(2'd1, 4'd2);
    adj(2'd2, 4'd5);
    adj(2'd3, 4'd9);
    check_mmss(0, "t2.adj", 2, 59);
    run = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    check_mmss(0, "t2.wrap", 0, 0);
    check("t2.wrapped", 32'(wrp[0]), 32'd1);
    check("t2.step", 32'(stp[0]), 32'd1);
    check_mmss(1, "t2.sat", 2, 59);
    check("t2.sat_done", 32'(dn[1]), 32'd1);
    check("t2.sat_step", 32'(stp[1]), 32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (stp[1]) pulses++;
    end
    check("t2.sat_pulses", 32'(pulses), 32'd0);

    // 3: countdown 01:00 -> 00:59, then 00:01 -> 00:00 with done
    run       = 1'b0;
    mode_down = 1'b1;
    adj(2'd0, 4'd0);
    adj(2'd1, 4'd1);
    adj(2'd2, 4'd0);
    adj(2'd3, 4'd0);
    run = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    check_mmss(0, "t3.borrow", 0, 59);
    run = 1'b0;
    adj(2'd1, 4'd0);
    adj(2'd2, 4'd0);
    adj(2'd3, 4'd1);
    run = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    check_mmss(0, "t3.zero", 0, 0);
    check("t3.done", 32'(dn[0]), 32'd1);
    check("t3.step", 32'(stp[0]), 32'd1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (stp[0]) pulses++;
    end
    check("t3.held_pulses", 32'(pulses), 32'd0);

    // 4: a write that coincides with a tick wins, and the prescaler restarts
    mode_down = 1'b0;
    run       = 1'b0;
    adj(2'd3, 4'd0);
    run = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    adj(2'd3, 4'd7);
    check("t4.sec_o", 32'(so[0]), 32'd7);
    check("t4.step", 32'(stp[0]), 32'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (stp[0]) pulses++;
    end
    check("t4.early_pulses", 32'(pulses), 32'd0);
    cyc();
    check("t4.step_late", 32'(stp[0]), 32'd1);
    check("t4.sec_o_late", 32'(so[0]), 32'd8);

    // 5: clamping of written digits
    run = 1'b0;
    adj(2'd2, 4'd9);
    check("t5.sec_t", 32'(st[0]), 32'd5);
    adj(2'd0, 4'd7);
    check("t5.u2.min_t", 32'(mt[2]), 32'd4);
    adj(2'd1, 4'd9);
    check("t5.u2.min_o", 32'(mo[2]), 32'd5);
    check("t5.u0.min_o", 32'(mo[0]), 32'd2);

    // 6: pause mid-second, resume, then reset
    adj(2'd0, 4'd1);
    adj(2'd1, 4'd2);
    adj(2'd2, 4'd3);
    adj(2'd3, 4'd4);
    check_mmss(2, "t6.adj", 12, 34);
    run = 1'b1;
    cyc();
    cyc();
    run = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    check_mmss(2, "t6.paused", 12, 34);
    run = 1'b1;
    cyc();
    check("t6.resume_step", 32'(stp[2]), 32'd1);
    check_mmss(2, "t6.resume", 12, 35);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_mmss(2, "t6.rst", 0, 0);
    check("t6.rst_done", 32'(dn[2]), 32'd0);

    // Random phase, checked against the model on every cycle
    for (int k = 0; k < 2000; k++) begin
      rst     = ($urandom_range(0, 399) == 0);
      run     = ($urandom_range(0, 7) != 0);
      adj_we  = ($urandom_range(0, 15) == 0);
      adj_sel = 2'($urandom_range(0, 3));
      adj_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) mode_down = ~mode_down;
      cyc();
    end
    rst    = 1'b0;
    adj_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
